// File: rtl/pms_mbox_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pms_mbox_pkg                                                     |
// | Shared types and constants for the I2C slave ingress mailbox.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pms_mbox_pkg;

  localparam int N_I2C_SLV       = 2;
  localparam int MBOX_FIFO_DEPTH = 8;
  localparam int MBOX_IRQ_THRESH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  len;
    logic        last;
  } mbox_entry_t;

  // Little-endian byte lane insert: lane k occupies bits [8k+7:8k].
  function automatic logic [31:0] mbox_lane_put(input logic [31:0] w,
                                                 input logic [1:0]  k,
                                                 input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pms_i2c_slv_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pms_i2c_slv_packer                                               |
// | Packs one I2C slave byte stream into little-endian 32-bit words. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pms_i2c_slv_packer
  import pms_mbox_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_last_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        grant_i,
  output logic        pend_o,
  output logic [31:0] word_o,
  output logic [2:0]  len_o,
  output logic        last_o
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_pend;
  logic [2:0]  r_len;
  logic        r_last;

  logic        w_acc;
  logic        w_done;
  logic [31:0] w_base;

  assign w_acc  = rx_valid_i & ~r_pend;
  assign w_done = w_acc & ((r_cnt == 2'd3) | rx_last_i);
  // Starting a fresh word zeroes the stale upper lanes of the previous one.
  assign w_base = (r_cnt == 2'd0) ? 32'h0 : r_word;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_cnt  <= 2'd0;
      r_word <= 32'h0;
      r_pend <= 1'b0;
      r_len  <= 3'd0;
      r_last <= 1'b0;
    end else begin
      if (grant_i) begin
        r_pend <= 1'b0;
      end
      if (w_acc) begin
        r_word <= mbox_lane_put(w_base, r_cnt, rx_data_i);
        if (w_done) begin
          r_pend <= 1'b1;
          r_len  <= {1'b0, r_cnt} + 3'd1;
          r_last <= rx_last_i;
          r_cnt  <= 2'd0;
        end else begin
          r_cnt  <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign rx_ready_o = ~r_pend;
  assign pend_o     = r_pend;
  assign word_o     = r_word;
  assign len_o      = r_len;
  assign last_o     = r_last;

endmodule
`default_nettype wire

// File: rtl/pms_i2c_slv_mbox.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pms_i2c_slv_mbox                                                 |
// | Round-robin merge of I2C slave packers into a shared word FIFO.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pms_i2c_slv_mbox
  import pms_mbox_pkg::*;
#(
  parameter int N_SLV      = N_I2C_SLV,
  parameter int FIFO_DEPTH = MBOX_FIFO_DEPTH,
  parameter int IRQ_THRESH = MBOX_IRQ_THRESH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [N_SLV-1:0][7:0]        rx_data_i,
  input  logic [N_SLV-1:0]             rx_last_i,
  input  logic [N_SLV-1:0]             rx_valid_i,
  output logic [N_SLV-1:0]             rx_ready_o,
  output logic [31:0]                  pop_data_o,
  output logic [1:0]                   pop_src_o,
  output logic [2:0]                   pop_len_o,
  output logic                         pop_last_o,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         irq_o
);

  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_CW = C_AW + 1;

  // Per-channel packer state, padded to four slots so a 2-bit index is always in range.
  logic [3:0]       w_pend;
  logic [31:0]      w_word [4];
  logic [2:0]       w_len  [4];
  logic [3:0]       w_last;
  logic [N_SLV-1:0] w_gnt;

  logic             w_gnt_vld;
  logic [1:0]       w_gnt_idx;
  logic [2:0]       w_scan;
  logic [1:0]       w_rr_nxt;
  logic             w_full;

  logic [1:0]       r_rr;
  logic [C_AW-1:0]  r_wptr;
  logic [C_AW-1:0]  r_rptr;
  logic [C_CW-1:0]  r_count;
  logic [C_CW-1:0]  r_lcnt;
  logic             r_irq;
  mbox_entry_t      r_mem [FIFO_DEPTH];

  mbox_entry_t      w_entry;
  mbox_entry_t      w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_pop_valid;
  logic [C_CW-1:0]  w_count_nxt;
  logic [C_CW-1:0]  w_lcnt_nxt;
  logic             w_irq_nxt;

  for (genvar i = 0; i < N_SLV; i++) begin : g_ch
    assign w_gnt[i] = w_gnt_vld & (w_gnt_idx == 2'(i));

    pms_i2c_slv_packer u_packer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .rx_data_i  (rx_data_i[i]),
      .rx_last_i  (rx_last_i[i]),
      .rx_valid_i (rx_valid_i[i]),
      .rx_ready_o (rx_ready_o[i]),
      .grant_i    (w_gnt[i]),
      .pend_o     (w_pend[i]),
      .word_o     (w_word[i]),
      .len_o      (w_len[i]),
      .last_o     (w_last[i])
    );
  end

  for (genvar i = N_SLV; i < 4; i++) begin : g_pad
    assign w_pend[i] = 1'b0;
    assign w_word[i] = 32'h0;
    assign w_len[i]  = 3'd0;
    assign w_last[i] = 1'b0;
  end

  assign w_full      = (r_count == C_CW'(FIFO_DEPTH));
  assign w_pop_valid = (r_count != '0);

  // First pending channel at or after the round-robin pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    w_scan    = 3'd0;
    for (int k = 0; k < N_SLV; k++) begin
      w_scan = {1'b0, r_rr} + 3'(k);
      if (w_scan >= 3'(N_SLV)) begin
        w_scan = w_scan - 3'(N_SLV);
      end
      if (!w_gnt_vld && w_pend[w_scan[1:0]] && !w_full && !flush_i) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[1:0];
      end
    end
  end

  always_comb begin
    w_rr_nxt = r_rr;
    if (w_gnt_vld) begin
      w_rr_nxt = (w_gnt_idx == 2'(N_SLV - 1)) ? 2'd0 : w_gnt_idx + 2'd1;
    end
  end

  assign w_entry.data = w_word[w_gnt_idx];
  assign w_entry.src  = w_gnt_idx;
  assign w_entry.len  = w_len[w_gnt_idx];
  assign w_entry.last = w_last[w_gnt_idx];

  assign w_head = r_mem[r_rptr];
  assign w_push = w_gnt_vld;
  assign w_pop  = w_pop_valid & pop_ready_i & ~flush_i;

  always_comb begin
    w_count_nxt = r_count;
    w_lcnt_nxt  = r_lcnt;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - C_CW'(1);
    end
    if ((w_push && w_entry.last) && !(w_pop && w_head.last)) begin
      w_lcnt_nxt = r_lcnt + C_CW'(1);
    end else if (!(w_push && w_entry.last) && (w_pop && w_head.last)) begin
      w_lcnt_nxt = r_lcnt - C_CW'(1);
    end
    w_irq_nxt = (w_count_nxt >= C_CW'(IRQ_THRESH)) | (w_lcnt_nxt != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr    <= 2'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lcnt  <= '0;
      r_irq   <= 1'b0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lcnt  <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_AW'(1);
      end
      r_rr    <= w_rr_nxt;
      r_count <= w_count_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && rst_ni) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Head fields read as zero whenever the FIFO is empty.
  assign pop_valid_o  = w_pop_valid;
  assign pop_data_o   = w_pop_valid ? w_head.data : 32'h0;
  assign pop_src_o    = w_pop_valid ? w_head.src  : 2'd0;
  assign pop_len_o    = w_pop_valid ? w_head.len  : 3'd0;
  assign pop_last_o   = w_pop_valid & w_head.last;
  assign fifo_count_o = r_count;
  assign irq_o        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pms_i2c_slv_mbox.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pms_i2c_slv_mbox                                              |
// | Self-checking bench: vector table, scoreboard and corner cases.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pms_i2c_slv_mbox;
  import pms_mbox_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int THR   = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [N-1:0][7:0] rx_data_i;
  logic [N-1:0]      rx_last_i;
  logic [N-1:0]      rx_valid_i;
  logic [N-1:0]      rx_ready_o;
  logic [31:0]       pop_data_o;
  logic [1:0]        pop_src_o;
  logic [2:0]        pop_len_o;
  logic              pop_last_o;
  logic              pop_valid_o;
  logic              pop_ready_i;
  logic [3:0]        fifo_count_o;
  logic              irq_o;

  int n_chk = 0;
  int n_err = 0;
  mbox_entry_t sb_q[$];

  typedef struct {
    logic        ch;
    int          n;
    logic [7:0]  b0, b1, b2, b3;
    logic        last;
    logic [31:0] exp_data;
    logic [2:0]  exp_len;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  pms_i2c_slv_mbox #(.N_SLV(N), .FIFO_DEPTH(DEPTH), .IRQ_THRESH(THR)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .rx_data_i    (rx_data_i),
    .rx_last_i    (rx_last_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .pop_data_o   (pop_data_o),
    .pop_src_o    (pop_src_o),
    .pop_len_o    (pop_len_o),
    .pop_last_o   (pop_last_o),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .fifo_count_o (fifo_count_o),
    .irq_o        (irq_o)
  );

  // Every accepted pop is matched against the oldest expected entry.
  always @(negedge clk) begin
    mbox_entry_t e_act;
    mbox_entry_t e_exp;
    if (rst_ni === 1'b1 && flush_i === 1'b0 && pop_valid_o === 1'b1 && pop_ready_i === 1'b1) begin
      e_act = '{data: pop_data_o, src: pop_src_o, len: pop_len_o, last: pop_last_o};
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got data=%h src=%0d, required no pop", e_act.data, e_act.src);
      end else begin
        e_exp = sb_q.pop_front();
        if (e_act !== e_exp) begin
          n_err++;
          $display("FAIL pop_entry: got data=%h src=%0d len=%0d last=%0d, required data=%h src=%0d len=%0d last=%0d",
                   e_act.data, e_act.src, e_act.len, e_act.last,
                   e_exp.data, e_exp.src, e_exp.len, e_exp.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic ch, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    rx_valid_i[ch] = 1'b1;
    rx_data_i[ch]  = d;
    rx_last_i[ch]  = l;
    while (rx_ready_o[ch] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout ch%0d: rx_ready_o=%b, required ready", ch, rx_ready_o);
    end
    step();
    rx_valid_i[ch] = 1'b0;
    rx_last_i[ch]  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d entries left, required 0", nm, sb_q.size());
    end
  endtask

  function automatic logic [7:0] byte_sel(input vec_t v, input int j);
    case (j)
      0:       return v.b0;
      1:       return v.b1;
      2:       return v.b2;
      default: return v.b3;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 2, 8'hAA, 8'hBB, 8'h00, 8'h00, 1'b1, 32'h0000BBAA, 3'd2};
    vecs[1] = '{1'b0, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 32'h00000001, 3'd1};
    vecs[2] = '{1'b1, 3, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 32'h00030201, 3'd3};
    vecs[3] = '{1'b0, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 32'hEFBEADDE, 3'd4};
    vecs[4] = '{1'b0, 1, 8'hC0, 8'h00, 8'h00, 8'h00, 1'b1, 32'h000000C0, 3'd1};
    vecs[5] = '{1'b0, 4, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 32'h40302010, 3'd4};
    vecs[6] = '{1'b1, 4, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b0, 32'hF00FA55A, 3'd4};
    vecs[7] = '{1'b1, 2, 8'h77, 8'h88, 8'h00, 8'h00, 1'b1, 32'h00008877, 3'd2};

    rst_ni = 1'b0; flush_i = 1'b0; pop_ready_i = 1'b0;
    rx_data_i = '0; rx_last_i = '0; rx_valid_i = '0;
    step(); step();
    chk("rst_pop_valid", 64'(pop_valid_o), 64'd0);
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_ready", 64'(rx_ready_o), 64'h3);
    chk("rst_pop_data", 64'(pop_data_o), 64'h0);
    rst_ni = 1'b1;
    step();

    // First-word latency on ch0
    send_byte(1'b0, 8'h11, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0);
    send_byte(1'b0, 8'h33, 1'b0);
    send_byte(1'b0, 8'h44, 1'b1);
    chk("lat_valid_t", 64'(pop_valid_o), 64'd0);
    chk("lat_ready_t", 64'(rx_ready_o), 64'h2);
    step();
    chk("lat_valid_t1", 64'(pop_valid_o), 64'd1);
    chk("lat_data", 64'(pop_data_o), 64'h44332211);
    chk("lat_len", 64'(pop_len_o), 64'd4);
    chk("lat_last", 64'(pop_last_o), 64'd1);
    chk("lat_src", 64'(pop_src_o), 64'd0);
    chk("lat_count", 64'(fifo_count_o), 64'd1);
    chk("lat_irq", 64'(irq_o), 64'd1);
    chk("lat_ready_t1", 64'(rx_ready_o), 64'h3);
    sb_q.push_back('{data: 32'h44332211, src: 2'd0, len: 3'd4, last: 1'b1});
    pop_ready_i = 1'b1;
    wait_drain("lat");

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte(vecs[i].ch, byte_sel(vecs[i], j), vecs[i].last && (j == vecs[i].n - 1));
      end
      sb_q.push_back('{data: vecs[i].exp_data, src: {1'b0, vecs[i].ch},
                       len: vecs[i].exp_len, last: vecs[i].last});
      wait_drain($sformatf("vec%0d", i));
    end

    // Simultaneous completions with the pointer at 0: ch0 then ch1, twice
    pop_ready_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rx_valid_i = 2'b11;
      rx_last_i  = 2'b11;
      rx_data_i[0] = (p == 0) ? 8'h31 : 8'h41;
      rx_data_i[1] = (p == 0) ? 8'h32 : 8'h42;
      step();
      rx_valid_i = 2'b00;
      rx_last_i  = 2'b00;
      chk("pair_ready_both", 64'(rx_ready_o), 64'h0);
      step();
      chk("pair_ready_ch0", 64'(rx_ready_o), 64'h1);
      step();
      chk("pair_ready_ch1", 64'(rx_ready_o), 64'h3);
      sb_q.push_back('{data: (p == 0) ? 32'h31 : 32'h41, src: 2'd0, len: 3'd1, last: 1'b1});
      sb_q.push_back('{data: (p == 0) ? 32'h32 : 32'h42, src: 2'd1, len: 3'd1, last: 1'b1});
    end
    chk("pair_count", 64'(fifo_count_o), 64'd4);
    chk("pair_head_src", 64'(pop_src_o), 64'd0);
    pop_ready_i = 1'b1;
    wait_drain("pair");

    // Fill the FIFO with non-last words, then stall ch1
    pop_ready_i = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(1'b0, 8'(w * 16 + j), 1'b0);
      end
      sb_q.push_back('{data: {8'(w * 16 + 3), 8'(w * 16 + 2), 8'(w * 16 + 1), 8'(w * 16)},
                       src: 2'd0, len: 3'd4, last: 1'b0});
    end
    step();
    chk("fill_count", 64'(fifo_count_o), 64'd8);
    for (int j = 0; j < 4; j++) begin
      send_byte(1'b1, 8'(8'hC1 + j), 1'b0);
    end
    step(); step(); step();
    chk("full_ready1", 64'(rx_ready_o[1]), 64'd0);
    chk("full_count", 64'(fifo_count_o), 64'd8);
    chk("full_irq", 64'(irq_o), 64'd1);
    sb_q.push_back('{data: 32'hC4C3C2C1, src: 2'd1, len: 3'd4, last: 1'b0});
    pop_ready_i = 1'b1;
    step();
    pop_ready_i = 1'b0;
    chk("full_pop_count", 64'(fifo_count_o), 64'd7);
    chk("full_pop_ready1", 64'(rx_ready_o[1]), 64'd0);
    step();
    chk("full_regrant_count", 64'(fifo_count_o), 64'd8);
    chk("full_regrant_ready1", 64'(rx_ready_o[1]), 64'd1);
    pop_ready_i = 1'b1;
    wait_drain("fill");
    chk("fill_empty_count", 64'(fifo_count_o), 64'd0);
    chk("fill_empty_irq", 64'(irq_o), 64'd0);

    // Flush with three entries queued and a half-packed word on ch1
    pop_ready_i = 1'b0;
    send_byte(1'b0, 8'hE1, 1'b1);
    send_byte(1'b0, 8'hE2, 1'b1);
    send_byte(1'b0, 8'hE3, 1'b1);
    step();
    chk("pre_flush_count", 64'(fifo_count_o), 64'd3);
    send_byte(1'b1, 8'h55, 1'b0);
    send_byte(1'b1, 8'h66, 1'b0);
    rx_valid_i[1] = 1'b1;
    rx_data_i[1]  = 8'h99;
    pop_ready_i   = 1'b1;
    flush_i       = 1'b1;
    step();
    flush_i       = 1'b0;
    rx_valid_i[1] = 1'b0;
    pop_ready_i   = 1'b0;
    chk("flush_count", 64'(fifo_count_o), 64'd0);
    chk("flush_valid", 64'(pop_valid_o), 64'd0);
    chk("flush_ready", 64'(rx_ready_o), 64'h3);
    chk("flush_irq", 64'(irq_o), 64'd0);
    for (int j = 0; j < 4; j++) begin
      send_byte(1'b1, 8'(j + 1), 1'b0);
    end
    sb_q.push_back('{data: 32'h04030201, src: 2'd1, len: 3'd4, last: 1'b0});
    pop_ready_i = 1'b1;
    wait_drain("flush");

    // Reset while ch1 holds a pending word and five entries are queued
    pop_ready_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      send_byte(1'b0, 8'(8'h70 + j), 1'b1);
    end
    step();
    chk("pre_rst_count", 64'(fifo_count_o), 64'd5);
    send_byte(1'b1, 8'h77, 1'b1);
    chk("pre_rst_ready", 64'(rx_ready_o), 64'h1);
    rst_ni = 1'b0;
    step();
    chk("rst2_count", 64'(fifo_count_o), 64'd0);
    chk("rst2_valid", 64'(pop_valid_o), 64'd0);
    chk("rst2_irq", 64'(irq_o), 64'd0);
    chk("rst2_ready", 64'(rx_ready_o), 64'h3);
    chk("rst2_head", {26'h0, pop_data_o, pop_src_o, pop_len_o, pop_last_o}, 64'h0);
    rst_ni = 1'b1;
    step();
    chk("post_rst_count", 64'(fifo_count_o), 64'd0);
    chk("post_rst_valid", 64'(pop_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
